// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
// MULDIV_ACCUM_EN adds MADD/MSUB to the set of long-running ops.
package muldiv_pkg;
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;

  localparam int DIV_STEPS = 32;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} state_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } mul_req_t;

  // Ops that occupy the unit for more than the issue cycle.
  function automatic logic is_long_op(input logic [2:0] op);
`ifdef MULDIV_ACCUM_EN
    return (op != OP_MTHI) && (op != OP_MTLO);
`else
    return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
`endif
  endfunction
endpackage

// File: rtl/muldiv_div_iter.sv
// Restoring divider datapath: one quotient bit per step, 33-bit partial
// remainder, unsigned operands (sign handling lives in muldiv_ctrl).
module div_iter
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quo,
  output logic [31:0] rem,
  output logic        last
);
  logic [32:0] prem;
  logic [31:0] q;
  logic [31:0] dvs;
  logic [5:0]  cnt;
  logic [33:0] trial;

  // Shift in the next dividend bit and try subtracting the divisor.
  assign trial = {prem, q[31]} - {2'b0, dvs};
  assign quo   = q;
  assign rem   = prem[31:0];
  assign last  = (cnt == 6'(DIV_STEPS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prem <= '0;
      q    <= '0;
      dvs  <= '0;
      cnt  <= '0;
    end else if (load) begin
      prem <= '0;
      q    <= dividend;
      dvs  <= divisor;
      cnt  <= '0;
    end else if (step) begin
      prem <= trial[33] ? {prem[31:0], q[31]} : trial[32:0];
      q    <= {q[30:0], ~trial[33]};
      cnt  <= cnt + 6'd1;
    end
  end
endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: FSM, multiplier, divide sign fix, HI/LO.
// Define MULDIV_ACCUM_EN to enable MADD/MSUB accumulate into {hi,lo}.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  state_t      state;
  mul_req_t    req;
  logic [1:0]  mul_cnt;
  logic        q_neg, r_neg;
  logic        accept, div_load, div_step, div_last;
  logic [31:0] div_quo, div_rem, div_a, div_b;
  logic signed [63:0] mul_a, mul_b;
  logic [63:0] prod, mul_res;

  assign accept   = start & (state == ST_IDLE) & ~flush;
  assign busy     = (state != ST_IDLE) | (accept & is_long_op(op));
  assign div_load = accept & ((op == OP_DIV) | (op == OP_DIVU));
  assign div_step = (state == ST_DIV) & ~flush;
  assign div_a    = (op == OP_DIV && src_a[31]) ? -src_a : src_a;
  assign div_b    = (op == OP_DIV && src_b[31]) ? -src_b : src_b;

  always_comb begin
    mul_a = (req.op == OP_MULTU) ? {32'b0, req.a} : {{32{req.a[31]}}, req.a};
    mul_b = (req.op == OP_MULTU) ? {32'b0, req.b} : {{32{req.b[31]}}, req.b};
    prod  = mul_a * mul_b;
`ifdef MULDIV_ACCUM_EN
    case (req.op)
      OP_MADD: mul_res = {hi, lo} + prod;
      OP_MSUB: mul_res = {hi, lo} - prod;
      default: mul_res = prod;
    endcase
`else
    mul_res = prod;
`endif
  end

  div_iter u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .step     (div_step),
    .dividend (div_a),
    .divisor  (div_b),
    .quo      (div_quo),
    .rem      (div_rem),
    .last     (div_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      req     <= '0;
      mul_cnt <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      // Flush wins over everything, including a completing write.
      if (flush) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: if (start) begin
            req <= '{op: op, a: src_a, b: src_b};
            case (op)
              OP_MTHI: hi <= src_a;
              OP_MTLO: lo <= src_a;
`ifdef MULDIV_ACCUM_EN
              OP_MADD, OP_MSUB,
`endif
              OP_MULT, OP_MULTU: begin
                state   <= ST_MUL;
                mul_cnt <= 2'(MUL_LAT - 1);
              end
              OP_DIV: begin
                state <= ST_DIV;
                q_neg <= src_a[31] ^ src_b[31];
                r_neg <= src_a[31];
              end
              OP_DIVU: begin
                state <= ST_DIV;
                q_neg <= 1'b0;
                r_neg <= 1'b0;
              end
              default: ;
            endcase
          end
          ST_MUL: begin
            if (mul_cnt == 2'd0) begin
              {hi, lo} <= mul_res;
              done     <= 1'b1;
              state    <= ST_IDLE;
            end else begin
              mul_cnt <= mul_cnt - 2'd1;
            end
          end
          ST_DIV: if (div_last) state <= ST_FIX;
          ST_FIX: begin
            lo    <= q_neg ? -div_quo : div_quo;
            hi    <= r_neg ? -div_rem : div_rem;
            done  <= 1'b1;
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl (MUL_LAT=2): issue timing, results,
// flush/reset abort, back-to-back issue and the optional accumulate ops.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  muldiv_ctrl #(.MUL_LAT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive(input logic s, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b);
    start = s; op = o; src_a = a; src_b = b;
  endtask

  task automatic test_reset;
    tick(2);
    chk_cnt++;
    if ({busy, done, hi, lo} !== 66'd0)
      $display("FAIL reset_held: busy=%b done=%b hi=%h lo=%h want all 0", busy, done, hi, lo);
    else pass_cnt++;
    rst = 1'b0;
    tick(1);
    #1;
    chk_cnt++;
    if ({busy, done, hi, lo} !== 66'd0)
      $display("FAIL reset_release: busy=%b done=%b hi=%h lo=%h want all 0", busy, done, hi, lo);
    else pass_cnt++;
  endtask

  task automatic test_mult;
    drive(1'b1, OP_MULT, 32'hFFFFFFFE, 32'd3);
    #1;
    chk_cnt++;
    if ({busy, done} !== 2'b10) $display("FAIL mult_T: busy/done=%b want 10", {busy, done});
    else pass_cnt++;
    tick(1); start = 1'b0; #1;
    chk_cnt++;
    if ({busy, done} !== 2'b10) $display("FAIL mult_T1: busy/done=%b want 10", {busy, done});
    else pass_cnt++;
    tick(1); #1;
    chk_cnt++;
    if ({busy, done} !== 2'b10) $display("FAIL mult_T2: busy/done=%b want 10", {busy, done});
    else pass_cnt++;
    tick(1); #1;
    chk_cnt++;
    if ({busy, done, hi, lo} !== {2'b01, 32'hFFFFFFFF, 32'hFFFFFFFA})
      $display("FAIL mult_T3: busy=%b done=%b hi=%h lo=%h want 0 1 ffffffff fffffffa",
               busy, done, hi, lo);
    else pass_cnt++;
  endtask

  task automatic test_div_back_to_back;
    int bad;
    drive(1'b1, OP_DIV, 32'hFFFFFFF9, 32'd2);
    #1;
    chk_cnt++;
    if (busy !== 1'b1) $display("FAIL div_issue_busy: busy=%b want 1", busy);
    else pass_cnt++;
    tick(1); start = 1'b0;
    bad = 0;
    for (int k = 1; k <= 33; k++) begin
      #1;
      if (!(busy === 1'b1 && done === 1'b0)) bad++;
      tick(1);
    end
    chk_cnt++;
    if (bad != 0) $display("FAIL div_busy_window: %0d bad cycles in T+1..T+33, want 0", bad);
    else pass_cnt++;
    #1;
    chk_cnt++;
    if ({busy, done, hi, lo} !== {2'b01, 32'hFFFFFFFF, 32'hFFFFFFFD})
      $display("FAIL div_result: busy=%b done=%b hi=%h lo=%h want 0 1 ffffffff fffffffd",
               busy, done, hi, lo);
    else pass_cnt++;
    // new request issued in the cycle done is high
    drive(1'b1, OP_DIVU, 32'd7, 32'd0);
    #1;
    chk_cnt++;
    if ({busy, done} !== 2'b11) $display("FAIL b2b_issue: busy/done=%b want 11", {busy, done});
    else pass_cnt++;
    tick(1); start = 1'b0;
    tick(33); #1;
    chk_cnt++;
    if ({busy, done, hi, lo} !== {2'b01, 32'd7, 32'hFFFFFFFF})
      $display("FAIL divu_zero: busy=%b done=%b hi=%h lo=%h want 0 1 00000007 ffffffff",
               busy, done, hi, lo);
    else pass_cnt++;
    tick(1); #1;
    chk_cnt++;
    if ({busy, done} !== 2'b00) $display("FAIL done_pulse: busy/done=%b want 00", {busy, done});
    else pass_cnt++;
  endtask

  task automatic test_div_overflow;
    drive(1'b1, OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    tick(1); start = 1'b0;
    tick(33); #1;
    chk_cnt++;
    if ({done, hi, lo} !== {1'b1, 32'h0, 32'h80000000})
      $display("FAIL div_overflow: done=%b hi=%h lo=%h want 1 00000000 80000000", done, hi, lo);
    else pass_cnt++;
  endtask

  task automatic test_mul_flush_last;
    drive(1'b1, OP_MULT, 32'd5, 32'd5);
    tick(1); start = 1'b0;
    tick(1); flush = 1'b1; #1;
    chk_cnt++;
    if (busy !== 1'b1) $display("FAIL mulflush_busy: busy=%b want 1", busy);
    else pass_cnt++;
    tick(1); flush = 1'b0; #1;
    chk_cnt++;
    if ({busy, done, hi, lo} !== {2'b00, 32'h0, 32'h80000000})
      $display("FAIL mulflush_nowrite: busy=%b done=%b hi=%h lo=%h want 0 0 00000000 80000000",
               busy, done, hi, lo);
    else pass_cnt++;
  endtask

  task automatic test_mtlo;
    drive(1'b1, OP_MTLO, 32'h12345678, 32'd0);
    #1;
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL mtlo_busy: busy=%b want 0", busy);
    else pass_cnt++;
    tick(1); start = 1'b0; #1;
    chk_cnt++;
    if ({busy, done, lo} !== {2'b00, 32'h12345678})
      $display("FAIL mtlo_write: busy=%b done=%b lo=%h want 0 0 12345678", busy, done, lo);
    else pass_cnt++;
  endtask

  task automatic test_flush_start;
    drive(1'b1, OP_MULT, 32'd3, 32'd4);
    flush = 1'b1;
    #1;
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL flushstart_busy: busy=%b want 0", busy);
    else pass_cnt++;
    tick(1); start = 1'b0; flush = 1'b0;
    tick(3); #1;
    chk_cnt++;
    if ({busy, done, hi, lo} !== {2'b00, 32'h0, 32'h12345678})
      $display("FAIL flushstart_ignored: busy=%b done=%b hi=%h lo=%h want 0 0 00000000 12345678",
               busy, done, hi, lo);
    else pass_cnt++;
  endtask

  task automatic test_div_flush;
    int bad;
    drive(1'b1, OP_MTHI, 32'h11111111, 32'd0);
    tick(1);
    drive(1'b1, OP_MTLO, 32'h11111111, 32'd0);
    tick(1);
    drive(1'b1, OP_DIV, 32'd100, 32'd7);
    tick(1); start = 1'b0;
    tick(19); flush = 1'b1; #1;
    chk_cnt++;
    if (busy !== 1'b1) $display("FAIL divflush_T20_busy: busy=%b want 1", busy);
    else pass_cnt++;
    tick(1); flush = 1'b0; #1;
    chk_cnt++;
    if ({busy, done, hi, lo} !== {2'b00, 32'h11111111, 32'h11111111})
      $display("FAIL divflush_T21: busy=%b done=%b hi=%h lo=%h want 0 0 11111111 11111111",
               busy, done, hi, lo);
    else pass_cnt++;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      tick(1); #1;
      if (done !== 1'b0 || hi !== 32'h11111111 || lo !== 32'h11111111) bad++;
    end
    chk_cnt++;
    if (bad != 0) $display("FAIL divflush_quiet: %0d cycles with done or hi/lo change, want 0", bad);
    else pass_cnt++;
  endtask

  task automatic test_accum;
    drive(1'b1, OP_MTHI, 32'h0, 32'd0);
    tick(1);
    drive(1'b1, OP_MTLO, 32'hFFFFFFFF, 32'd0);
    tick(1);
    drive(1'b1, OP_MADD, 32'd1, 32'd1);
    #1;
`ifdef MULDIV_ACCUM_EN
    chk_cnt++;
    if (busy !== 1'b1) $display("FAIL madd_busy: busy=%b want 1", busy);
    else pass_cnt++;
    tick(1); start = 1'b0;
    tick(2); #1;
    chk_cnt++;
    if ({done, hi, lo} !== {1'b1, 32'd1, 32'd0})
      $display("FAIL madd_result: done=%b hi=%h lo=%h want 1 00000001 00000000", done, hi, lo);
    else pass_cnt++;
    drive(1'b1, OP_MSUB, 32'd2, 32'd3);
    tick(1); start = 1'b0;
    tick(2); #1;
    chk_cnt++;
    if ({done, hi, lo} !== {1'b1, 32'd0, 32'hFFFFFFFA})
      $display("FAIL msub_result: done=%b hi=%h lo=%h want 1 00000000 fffffffa", done, hi, lo);
    else pass_cnt++;
`else
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL madd_off_busy: busy=%b want 0", busy);
    else pass_cnt++;
    tick(1); start = 1'b0;
    tick(3); #1;
    chk_cnt++;
    if ({busy, done, hi, lo} !== {2'b00, 32'h0, 32'hFFFFFFFF})
      $display("FAIL madd_off_nowrite: busy=%b done=%b hi=%h lo=%h want 0 0 00000000 ffffffff",
               busy, done, hi, lo);
    else pass_cnt++;
`endif
  endtask

  task automatic test_reset_mid;
    drive(1'b1, OP_DIV, 32'd9, 32'd2);
    tick(1); start = 1'b0;
    tick(9); rst = 1'b1; #1;
    chk_cnt++;
    if ({busy, done, hi, lo} !== 66'd0)
      $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h want all 0", busy, done, hi, lo);
    else pass_cnt++;
    tick(1); rst = 1'b0;
    tick(1);
    drive(1'b1, OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    tick(1); start = 1'b0;
    tick(2); #1;
    chk_cnt++;
    if ({busy, done, hi, lo} !== {2'b01, 32'hFFFFFFFE, 32'h1})
      $display("FAIL multu_after_reset: busy=%b done=%b hi=%h lo=%h want 0 1 fffffffe 00000001",
               busy, done, hi, lo);
    else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div_back_to_back;
    test_div_overflow;
    test_mul_flush_last;
    test_mtlo;
    test_flush_start;
    test_div_flush;
    test_accum;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencer for the HI/LO multiply/divide resource. It accepts one EX-stage request at a time and runs either a MUL_LAT-cycle pipelined multiplier or a 32-iteration restoring divider. It owns the HI/LO registers and drives `busy`, which the stall unit ANDs with its HI/LO-read-in-ID signal. A MEM1 exception flush cancels the in-flight operation without touching HI/LO.

## Interface
- MUL_LAT, 2, multiplier latency in cycles; legal range 1..4.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  EX request valid.
- op  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB.
- src_a  in  32  rs operand (dividend / multiplicand / MTHI/MTLO data).
- src_b  in  32  rt operand (divisor / multiplier).
- flush  in  1  exception flush; kills any in-flight or same-cycle request.
- busy  out  1  HI/LO not yet valid; drives stall `isbusy`.
- done  out  1  one-cycle pulse; HI/LO updated by a multi-cycle operation.
- hi  out  32  HI register.
- lo  out  32  LO register.

## Operation
- States: IDLE, MUL, DIV, FIX.
- Accept: a request is accepted when start=1, state=IDLE and flush=0. Requests with start=1 in any other state are ignored.
- MTHI/MTLO: written at the accepting edge; no state change, no busy, no done.
- MULT/MULTU: IDLE→MUL. A counter loads MUL_LAT-1. The product is 64-bit: signed×signed for MULT, unsigned for MULTU. When the counter reaches 0, {hi,lo} is written and the state returns to IDLE.
- DIV/DIVU:
  - Accept edge: IDLE→DIV. Latch |a|, |b| for DIV, raw values for DIVU, plus the quotient-sign and remainder-sign flags.
  - DIV state: 32 restoring iterations, 1 bit per cycle, 33-bit partial remainder.
  - Then DIV→FIX. FIX negates the quotient if the operand signs differ, and negates the remainder if the dividend was negative. It writes lo=quotient, hi=remainder, then returns to IDLE.
- Divide by zero runs the full sequence; the natural result is lo=0xFFFFFFFF (before sign fix) and hi=dividend.
- Signed overflow (0x80000000 / -1): lo=0x80000000, hi=0.
- busy = (state≠IDLE) | (start & op∈{0,1,2,3,6,7} & state==IDLE & ~flush). The combinational term covers a HI/LO reader in ID during the issue cycle.
- flush=1 forces state→IDLE at the next edge. No HI/LO write and no done, including in the final write cycle; flush wins over completion.
- Reset: state=IDLE, hi=0, lo=0, busy=0, done=0, counters=0. Reset mid-operation aborts the operation immediately.

## Timing
- Request accepted at the edge ending cycle T.
- MUL: busy high in cycles T..T+MUL_LAT; HI/LO written at the edge ending T+MUL_LAT; done=1 in cycle T+MUL_LAT+1; busy=0 from T+MUL_LAT+1.
- DIV: iterations in cycles T+1..T+32; FIX in T+33; HI/LO written at the edge ending T+33; done=1 in T+34; busy=0 from T+34.
- MTHI/MTLO: new value visible on hi/lo in cycle T+1.
- Back-to-back issue: a new request is accepted in the cycle done is high.

## Configuration
- MULDIV_ACCUM_EN defined:
  - op 6 (MADD) writes {hi,lo} + signed(a×b).
  - op 7 (MSUB) writes {hi,lo} − signed(a×b).
  - Both use the MUL path and MUL timing, with 64-bit wrap-around.
  - The accumulate reads {hi,lo} at the write edge, so an intervening MTHI/MTLO cannot occur (busy blocks it).
- Undefined:
  - op 6/7 are not accepted: no busy, no write.
  - The accumulate adder is absent.

## Structure
- Package muldiv_pkg holds:
  - op encoding localparams (OP_MULT..OP_MSUB);
  - state encoding (ST_IDLE, ST_MUL, ST_DIV, ST_FIX);
  - DIV_STEPS=32.
- Sub-module div_iter is the restoring-divider datapath: load, step, partial remainder/quotient registers, and 6-bit step count. muldiv_ctrl owns the FSM, sign fix, multiplier pipeline and HI/LO.

## Test plan
- MULT a=0xFFFFFFFE (−2), b=3, MUL_LAT=2 → busy high in T..T+2; done in T+3; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- DIV a=−7, b=2 → done in T+34; lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). DIVU a=7, b=0 → lo=0xFFFFFFFF, hi=7.
- DIV started with hi=lo=0x11111111; flush=1 at cycle T+20 → busy=0 from T+21; no done; hi/lo remain 0x11111111.
- MTLO 0x12345678 → lo=0x12345678 in T+1; busy never high. start=1 with flush=1 for MULT → ignored, busy=0.
- MULDIV_ACCUM_EN: hi=0, lo=0xFFFFFFFF; MADD a=1, b=1 → hi=1, lo=0. Same op with macro undefined → hi/lo unchanged, busy=0.
- Reset asserted at cycle T+10 of a DIV → hi=lo=0, busy=0 immediately; next MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=1.
